pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8: bits resolved per pipeline stage.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 The block SHALL have port sub, input, 1 bit: 1 selects A - B, 0 selects A + B + cin.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-012 The block SHALL have port S, output, WIDTH bits: the sum or difference.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1 (for sub=1, 1 means no borrow).

Function
REQ-014 Parameters SHALL satisfy WIDTH % CHUNK == 0 and CHUNK >= 1; NST = WIDTH/CHUNK stages; violation fails elaboration.
REQ-015 {cout,S} SHALL equal A + B + cin (WIDTH+1-bit result) when sub=0, and A + ~B + 1 when sub=1.
REQ-016 Each stage k SHALL resolve chunk k with a combinational carry-lookahead, taking carry-in from the stage k-1 register (stage 0: effective carry-in).
REQ-017 Upper operand chunks and lower result chunks SHALL be skewed or deskewed through registers so that each transaction stays aligned.
REQ-018 An input SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-019 Its result SHALL appear with out_valid=1 exactly NST cycles after acceptance when there is no stall.
REQ-020 A stall SHALL be defined as out_valid=1 and out_ready=0.
REQ-021 During a stall the whole pipeline SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-022 Throughput SHALL be 1 transaction/cycle; order SHALL be preserved; no transaction SHALL be dropped or duplicated.
REQ-023 S and cout SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Bubbles (in_valid=0) SHALL propagate as invalid slots; outputs under out_valid=0 are don't-care except after reset.

Reset
REQ-025 Asserting rst SHALL asynchronously clear every stage valid bit, out_valid, S, cout and all internal carries to 0, at any time including mid-stream; in-flight transactions are discarded.
REQ-026 in_ready SHALL be 1 while in reset and after reset, since no stall is possible.
REQ-027 The first input SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro PIPELINED_CLA_ADDER_OVF_EN, when defined, SHALL add output ovf (1 bit): two's-complement signed overflow, equal to carry into MSB XOR carry out of MSB, aligned with S, reset to 0.
REQ-029 Without PIPELINED_CLA_ADDER_OVF_EN, port ovf and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package adder_pkg SHALL hold the default WIDTH/CHUNK constants and the per-stage pipeline record typedef (valid, operand remainders, partial sum, carry).
REQ-031 One sub-module, cla_chunk (parametrised CHUNK; inputs a, b, ci; outputs s, co; purely combinational generate/propagate lookahead), SHALL be instantiated NST times.

Verification
REQ-032 Add test: WIDTH=32, CHUNK=8: A=FFFFFFFF, B=00000001, cin=0, sub=0 -> after 4 cycles S=00000000, cout=1.
REQ-033 Subtract test: A=00000005, B=00000007, sub=1 -> S=FFFFFFFE, cout=0; then A=7, B=5, sub=1 -> S=00000002, cout=1.
REQ-034 Backpressure test: 6 back-to-back inputs A=i, B=i (i=1..6), with out_ready=0 for cycles 5-7 -> outputs 2,4,...,12 in order, in_ready=0 exactly during the stall, each output held stable.
REQ-035 Reset test: assert rst with 3 transactions in flight -> out_valid=0 and S=0 immediately, no stale output after release, and a fresh input yields the correct result 4 cycles later.
REQ-036 Overflow test (PIPELINED_CLA_ADDER_OVF_EN): A=7FFFFFFF, B=1 -> ovf=1; A=80000000, B=1, sub=1 -> ovf=1; A=1, B=1 -> ovf=0.
REQ-037 Random test: 10k random A/B/cin/sub with random in_valid/out_ready, WIDTH in {32, 64} and CHUNK in {4, 8, 16}, checked against a reference-model scoreboard -> zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared constants and the pipeline record for pipelined_cla_adder.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits resolved per stage
//   MAX_WIDTH             : widest operand the record can carry
//   stage_t               : one pipeline slot (valid, carry, operands, sum)
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int MAX_WIDTH = 64;

    // Operands travel with the slot so that the upper chunks reach the
    // stage that resolves them in step with their carry; the partial sum
    // fills in one chunk per stage, so finished low chunks stay aligned
    // with the rest of the transaction.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [MAX_WIDTH-1:0] opa;
        logic [MAX_WIDTH-1:0] opb;
        logic [MAX_WIDTH-1:0] psum;
    } stage_t;

endpackage

// File: rtl/pipelined_cla_adder_cla_chunk.sv
// ---------------------------------------------------------------------------
// cla_chunk
// Purely combinational carry-lookahead adder for one CHUNK-bit slice.
//   a, b : slice operands
//   ci   : carry into bit 0 of the slice
//   s    : slice sum
//   co   : carry out of the top bit of the slice
// ---------------------------------------------------------------------------
module cla_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded as a flat sum of products of generate and
    // propagate terms, so no carry depends on the carry below it:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
    always_comb begin
        logic acc;
        logic run;
        acc  = 1'b0;
        run  = 1'b1;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & run);
                run = run & p[j];
            end
            c[i+1] = acc | (run & ci);
        end
    end

    assign s  = p ^ c[CHUNK-1:0];
    assign co = c[CHUNK];

endmodule

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
// WIDTH-bit adder/subtractor split into WIDTH/CHUNK carry-lookahead stages,
// one chunk per stage, with a valid/ready handshake and a full-pipeline
// stall when the output is held.
//   clk, rst           : clock (rising edge), async active-high reset
//   in_valid, in_ready : input handshake
//   A, B, cin, sub     : operands; sub=1 gives A-B, sub=0 gives A+B+cin
//   out_valid,out_ready: output handshake
//   S, cout            : result and carry out (cout=1 means no borrow on sub)
//   ovf                : signed overflow, only with PIPELINED_CLA_ADDER_OVF_EN
// Result appears WIDTH/CHUNK cycles after acceptance when not stalled.
// ---------------------------------------------------------------------------
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NST = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || WIDTH > MAX_WIDTH || WIDTH < 1) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of CHUNK, CHUNK >= 1, WIDTH <= MAX_WIDTH");
    end

    stage_t pipe [NST];
    stage_t nxt  [NST];
    stage_t last;
    logic   stall;
    logic   unused_last;

    // A held result freezes every stage, so the input side must refuse
    // new work in exactly those cycles.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < NST; k++) begin : g_stage
        stage_t               src;
        logic [CHUNK-1:0]     s_k;
        logic                 c_k;
        logic [MAX_WIDTH-1:0] merged;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1, so B is inverted once here and the
            // forced carry-in supplies the +1; cin only matters for add.
            assign src = {in_valid,
                          sub | cin,
                          MAX_WIDTH'(A),
                          MAX_WIDTH'(sub ? ~B : B),
                          {MAX_WIDTH{1'b0}}};
        end else begin : g_body
            assign src = pipe[k-1];
        end

        cla_chunk #(
            .CHUNK (CHUNK)
        ) u_cla (
            .a  (src.opa[k*CHUNK +: CHUNK]),
            .b  (src.opb[k*CHUNK +: CHUNK]),
            .ci (src.carry),
            .s  (s_k),
            .co (c_k)
        );

        // Drop this stage's chunk into the travelling partial sum; chunks
        // below it were written by earlier stages of the same slot.
        always_comb begin
            merged                    = src.psum;
            merged[k*CHUNK +: CHUNK]  = s_k;
        end

        assign nxt[k] = {src.valid, c_k, src.opa, src.opb, merged};
    end

    // All stage registers advance together or hold together; bubbles move
    // through as slots with valid cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NST; k++) begin
                pipe[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NST; k++) begin
                pipe[k] <= nxt[k];
            end
        end
    end

    assign last = pipe[NST-1];

    // The output register adds the final cycle of latency and is the thing
    // the consumer sees held during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            cout      <= 1'b0;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (!stall) begin
            out_valid <= last.valid;
            S         <= last.psum[WIDTH-1:0];
            cout      <= last.carry;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit and its
            // operands, so the chunk adder needs no extra output.
            ovf       <= last.carry ^ (last.opa[WIDTH-1] ^ last.opb[WIDTH-1] ^ last.psum[WIDTH-1]);
`endif
        end
    end

    assign unused_last = ^{last.opa, last.opb, last.psum};

endmodule
